mem_copy_engine: RTL

Sequential bus master that drives the write/read port of the 512×16 main RAM to perform block copy (memmove semantics) or block fill without CPU involvement. It sits between the control unit and the RAM port: the CPU side issues a one-cycle start with operands, and the engine then owns address, data-in and load until done. It is the initiator counterpart of the RAM's responder port. RAM read is combinational from address; RAM write commits on the clk edge when load=1.

---
 rtl/mem_copy_engine_pkg.sv | 17 +
 rtl/mem_copy_engine_if.sv | 34 +++
 rtl/mem_copy_engine_ptr_step.sv | 16 +
 rtl/mem_copy_engine.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy/fill engine: default bus widths,
// maximum transfer length and the controller state encoding.
package mem_copy_engine_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;
  localparam int MAX_LEN    = 512;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Control and RAM-port bundle of the copy engine. The master side is the
// engine itself; the slave side is the CPU control plus the RAM responder.
interface mem_copy_engine_if
  import mem_copy_engine_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] fill_val;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_load;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;

  modport master (
    input  start, mode, src, dst, len, fill_val, mem_rdata,
    output mem_addr, mem_data, mem_load, busy, done, count
  );

  modport slave (
    output start, mode, src, dst, len, fill_val, mem_rdata,
    input  mem_addr, mem_data, mem_load, busy, done, count
  );

endinterface

// File: rtl/mem_copy_engine_ptr_step.sv
// ptr_step unit: wrap-around increment (dir=0) or decrement (dir=1) of a
// word address. Natural ADDR_W-bit overflow gives the modulo-512 behaviour.
module mem_copy_engine_ptr_step #(
  parameter int ADDR_W = 9
) (
  input  logic [ADDR_W-1:0] ptr,
  input  logic              dir,
  output logic [ADDR_W-1:0] nxt
);

  // Single adder/subtractor selected by direction.
  always_comb begin
    nxt = dir ? (ptr - ADDR_W'(1)) : (ptr + ADDR_W'(1));
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy (memmove ordering) / block fill bus master for the main RAM.
// Copy alternates READ and WRITE cycles through a one-word holding register;
// fill writes one word per cycle. Bus outputs depend only on registered state.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_copy_engine_if.master bus
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  // Saturate the requested word count to the RAM size.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  state_t            state, state_nxt;
  logic              desc_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_inc;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [ADDR_W-1:0] src_step, dst_step;
  logic [ADDR_W:0]   len_c;
  logic              desc_c;
  logic [ADDR_W-1:0] src_init, dst_init;
  logic              accept;
  logic              last;

  assign accept    = (state == ST_IDLE) && bus.start;
  assign len_c     = clamp_len(bus.len);
  // Copy runs backwards only when the destination lies above the source,
  // so an overlapping tail is read before it is overwritten.
  assign desc_c    = !bus.mode && (bus.dst > bus.src);
  assign src_init  = desc_c ? (bus.src + len_c[ADDR_W-1:0] - ADDR_W'(1)) : bus.src;
  assign dst_init  = desc_c ? (bus.dst + len_c[ADDR_W-1:0] - ADDR_W'(1)) : bus.dst;
  assign count_inc = count_q + (ADDR_W+1)'(1);
  assign last      = (count_inc == len_q);

  mem_copy_engine_ptr_step #(.ADDR_W(ADDR_W)) u_src_step (
    .ptr (src_ptr),
    .dir (desc_q),
    .nxt (src_step)
  );

  mem_copy_engine_ptr_step #(.ADDR_W(ADDR_W)) u_dst_step (
    .ptr (dst_ptr),
    .dir (desc_q),
    .nxt (dst_step)
  );

  // Controller state and word counter; the only registers needing reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        count_q <= '0;
      end else if (state == ST_WRITE || state == ST_FILL) begin
        count_q <= count_inc;
      end
    end
  end

  // Operand latches, pointers and the copy holding register.
  always_ff @(posedge clk) begin
    if (accept) begin
      desc_q  <= desc_c;
      len_q   <= len_c;
      fill_q  <= bus.fill_val;
      src_ptr <= src_init;
      dst_ptr <= dst_init;
    end
    if (state == ST_READ) begin
      data_reg <= bus.mem_rdata;
    end
    if (state == ST_WRITE) begin
      src_ptr <= src_step;
      dst_ptr <= dst_step;
    end
    if (state == ST_FILL) begin
      dst_ptr <= dst_step;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (len_c == '0)   state_nxt = ST_DONE;
          else if (bus.mode) state_nxt = ST_FILL;
          else               state_nxt = ST_READ;
        end
      end
      ST_READ:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = last ? ST_DONE : ST_READ;
      ST_FILL:  state_nxt = last ? ST_DONE : ST_FILL;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Bus and status outputs, decoded from registered state only.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_data = '0;
    bus.mem_load = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    unique case (state)
      ST_READ: begin
        bus.mem_addr = src_ptr;
        bus.busy     = 1'b1;
      end
      ST_WRITE: begin
        bus.mem_addr = dst_ptr;
        bus.mem_data = data_reg;
        bus.mem_load = 1'b1;
        bus.busy     = 1'b1;
      end
      ST_FILL: begin
        bus.mem_addr = dst_ptr;
        bus.mem_data = fill_q;
        bus.mem_load = 1'b1;
        bus.busy     = 1'b1;
      end
      ST_DONE: begin
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.count = count_q;

endmodule
